// File: rtl/bsg_credit_return_batcher.sv
// bsg_credit_return_batcher: batches locally freed credits into token groups
// returned over valid/ready, with a timeout bounding how long a credit waits.
module bsg_credit_return_batcher #(
  parameter int max_val_p = 1023,
  parameter int max_step_p = 1,
  parameter int batch_p = 4,
  parameter int timeout_p = 16,
  localparam int cw = $clog2(max_val_p + 1),
  localparam int sw = $clog2(max_step_p + 1),
  localparam int tw = $clog2(timeout_p + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          credit_v_i,
  input  logic [sw-1:0] credit_cnt_i,
  input  logic          flush_i,
  output logic          tokens_v_o,
  output logic [cw-1:0] tokens_o,
  input  logic          ready_i,
  output logic [cw-1:0] outstanding_o,
  output logic          overflow_o
);
  typedef enum logic [1:0] {IDLE, ACCUM, OFFER} state_e;
  state_e state_q, state_d;
  logic [cw-1:0] pending_q, pending_d, tokens_q, tokens_d, arr_c;
  logic [tw-1:0] timer_q, timer_d;
  logic overflow_q, overflow_d, ovf, trig;
  logic [sw-1:0] arr;
  logic [31:0] tot;
  // arrivals that would push outstanding past max_val_p are clipped to fit
  assign arr = credit_v_i ? credit_cnt_i : '0;
  assign tot = 32'(pending_q) + 32'(tokens_q) + 32'(arr);
  assign ovf = tot > 32'(max_val_p);
  assign arr_c = ovf ? cw'(max_val_p) - pending_q - tokens_q : cw'(arr);
  assign trig = (pending_q >= cw'(batch_p)) | (timer_q == tw'(timeout_p - 1)) | flush_i;
  always_ff @(posedge clk_i)
    if (!reset_i) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      tokens_q   <= '0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      tokens_q   <= tokens_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
    end
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    tokens_d   = tokens_q;
    timer_d    = '0;
    overflow_d = overflow_q | ovf;
    case (state_q)
      IDLE: if (arr_c != '0) begin
        state_d   = ACCUM;
        pending_d = arr_c;
      end
      ACCUM: if (trig) begin
        state_d   = OFFER;
        tokens_d  = pending_q;
        pending_d = arr_c;
      end else begin
        pending_d = pending_q + arr_c;
        timer_d   = timer_q + tw'(1);
      end
      OFFER: begin
        pending_d = pending_q + arr_c;
        if (ready_i) begin
          tokens_d = '0;
          state_d  = (pending_d == '0) ? IDLE : ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    tokens_v_o    = state_q == OFFER;
    tokens_o      = tokens_v_o ? tokens_q : '0;
    outstanding_o = pending_q + tokens_q;
    overflow_o    = overflow_q;
  end
endmodule

// File: tb/tb_bsg_credit_return_batcher.sv
// tb_bsg_credit_return_batcher: directed checks of batching, timeout, flush,
// backpressure, saturation and mid-offer reset.
module tb_bsg_credit_return_batcher;
  logic clk = 1'b0, reset_i = 1'b0, credit_v_i = 1'b0, flush_i = 1'b0, ready_i = 1'b0;
  logic [2:0] credit_cnt_i = '0;
  logic tokens_v_o, overflow_o;
  logic [2:0] tokens_o, outstanding_o;
  int n_cmp = 0, n_bad = 0;

  bsg_credit_return_batcher #(.max_val_p(7), .max_step_p(4), .batch_p(4), .timeout_p(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .credit_v_i(credit_v_i), .credit_cnt_i(credit_cnt_i),
    .flush_i(flush_i), .tokens_v_o(tokens_v_o), .tokens_o(tokens_o), .ready_i(ready_i),
    .outstanding_o(outstanding_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arrive(input logic [2:0] n);
    credit_v_i = 1'b1;
    credit_cnt_i = n;
    step();
    credit_v_i = 1'b0;
    credit_cnt_i = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] t, input logic [2:0] o);
    chk({tag, ".v"}, 32'(tokens_v_o), 32'(v));
    chk({tag, ".tok"}, 32'(tokens_o), 32'(t));
    chk({tag, ".out"}, 32'(outstanding_o), 32'(o));
  endtask

  initial begin
    step(); step();
    chk_out("rst", 0, 0, 0);
    chk("rst.ovf", 32'(overflow_o), 0);
    reset_i = 1'b1;
    // lone credit returned by timeout at t+17
    ready_i = 1'b1;
    arrive(1);
    chk_out("to.t1", 0, 0, 1);
    repeat (15) step();
    chk_out("to.t16", 0, 0, 1);
    step();
    chk_out("to.t17", 1, 1, 1);
    step();
    chk_out("to.fired", 0, 0, 0);
    // full batch in one cycle: offer at t+2
    ready_i = 1'b0;
    arrive(4);
    chk_out("b4.t1", 0, 0, 4);
    step();
    chk_out("b4.t2", 1, 4, 4);
    // backpressure: offer held while credits keep arriving
    step(); arrive(1); step(); step(); arrive(1); step(); step(); arrive(1); step(); step(); step();
    chk_out("bp.held", 1, 4, 7);
    chk("bp.ovf", 32'(overflow_o), 0);
    ready_i = 1'b1;
    step();
    chk_out("bp.fire", 0, 0, 3);
    ready_i = 1'b0;
    repeat (15) step();
    chk_out("bp.acc15", 0, 0, 3);
    step();
    chk_out("bp.offer2", 1, 3, 3);
    ready_i = 1'b1;
    step();
    chk_out("bp.idle", 0, 0, 0);
    ready_i = 1'b0;
    // flush with nothing pending has no effect
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk_out("fl.idle", 0, 0, 0);
    step();
    chk_out("fl.idle2", 0, 0, 0);
    // flush forces out a partial group next cycle
    arrive(2);
    step();
    chk_out("fl.acc", 0, 0, 2);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk_out("fl.offer", 1, 2, 2);
    ready_i = 1'b1;
    step();
    chk_out("fl.fired", 0, 0, 0);
    ready_i = 1'b0;
    // batch reached over two arrivals; arrival in trigger cycle goes to next group
    arrive(3);
    arrive(1);
    chk_out("bt.t1", 0, 0, 4);
    arrive(2);
    chk_out("bt.t2", 1, 4, 6);
    ready_i = 1'b1;
    step();
    chk_out("bt.fired", 0, 0, 2);
    ready_i = 1'b0;
    // saturation at max_val_p=7
    reset_i = 1'b0;
    step();
    reset_i = 1'b1;
    chk_out("sat.rst", 0, 0, 0);
    repeat (7) arrive(1);
    chk_out("sat.c7", 1, 4, 7);
    chk("sat.ovf7", 32'(overflow_o), 0);
    arrive(1);
    chk_out("sat.c8", 1, 4, 7);
    chk("sat.ovf8", 32'(overflow_o), 1);
    ready_i = 1'b1;
    step();
    chk_out("sat.fire", 0, 0, 3);
    ready_i = 1'b0;
    step(); step();
    chk("sat.sticky", 32'(overflow_o), 1);
    // reset while offering, with a concurrent arrival
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk_out("mr.offer", 1, 3, 3);
    reset_i = 1'b0;
    credit_v_i = 1'b1;
    credit_cnt_i = 3'd2;
    step();
    reset_i = 1'b1;
    credit_v_i = 1'b0;
    credit_cnt_i = '0;
    chk_out("mr.rst", 0, 0, 0);
    chk("mr.ovf", 32'(overflow_o), 0);
    step();
    chk_out("mr.after", 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
